// File: rtl/conv_stream_driver_if.sv
// Stream bundle between conv_stream_driver and the convolver.
// X travels driver -> convolver, Y travels convolver -> driver.
interface conv_stream_driver_if #(
    parameter int T = 8
);
    // X stream (driver is the source)
    logic                m_valid_x;
    logic signed [T-1:0] m_data_x;
    logic                m_ready_x;

    // Y stream (driver is the sink)
    logic                s_valid_y;
    logic signed [T-1:0] s_data_y;
    logic                s_ready_y;

    // Driver side: sources X, sinks Y
    modport master (
        output m_valid_x,
        output m_data_x,
        input  m_ready_x,
        input  s_valid_y,
        input  s_data_y,
        output s_ready_y
    );

    // Convolver side: sinks X, sources Y
    modport slave (
        input  m_valid_x,
        input  m_data_x,
        output m_ready_x,
        output s_valid_y,
        output s_data_y,
        input  s_ready_y
    );
endinterface

// File: rtl/conv_stream_driver.sv
// conv_stream_driver: host-loaded X buffer streamed out as a valid/ready
// master, convolver results captured into a Y buffer for host readback.
// The X buffer has a registered read, so a one-word output register plus a
// one-word skid entry absorb the read latency and keep one beat per cycle.
module conv_stream_driver #(
    parameter int T = 8,
    parameter int N = 128,
    parameter int M = 32
) (
    input  logic                        clk,
    input  logic                        reset,

    // host side: X buffer load and transfer control
    input  logic                        wr_en,
    input  logic [$clog2(N)-1:0]        wr_addr,
    input  logic signed [T-1:0]         wr_data,
    input  logic                        start,

    // stream ports toward the convolver
    conv_stream_driver_if.master        strm,

    // host side: Y buffer readback and status
    input  logic [$clog2(N-M+1)-1:0]    rd_addr,
    output logic signed [T-1:0]         rd_data,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(N-M+2)-1:0]    y_count
);

    localparam int Y_LEN   = N - M + 1;
    localparam int XA      = $clog2(N);
    localparam int YA      = $clog2(Y_LEN);
    localparam int YC_W    = $clog2(Y_LEN + 1);
    localparam int TC_W    = $clog2(N + 1);
    localparam int X_DEPTH = 1 << XA;
    localparam int Y_DEPTH = 1 << YA;

    localparam logic [TC_W-1:0] N_C     = TC_W'(N);
    localparam logic [YC_W-1:0] Y_LEN_C = YC_W'(Y_LEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // control and pipeline registers
    state_t              state_q,      state_d;
    logic [TC_W-1:0]     tx_cnt_q,     tx_cnt_d;
    logic [TC_W-1:0]     fetch_idx_q,  fetch_idx_d;
    logic                rvalid_q,     rvalid_d;
    logic                out_valid_q,  out_valid_d;
    logic signed [T-1:0] out_data_q,   out_data_d;
    logic                skid_valid_q, skid_valid_d;
    logic signed [T-1:0] skid_data_q,  skid_data_d;
    logic                s_ready_y_q,  s_ready_y_d;
    logic [YC_W-1:0]     y_count_q,    y_count_d;
    logic                busy_q,       busy_d;
    logic                done_q,       done_d;

    // buffers (contents are never reset)
    logic signed [T-1:0] x_mem [0:X_DEPTH-1];
    logic signed [T-1:0] y_mem [0:Y_DEPTH-1];
    logic signed [T-1:0] x_rdata_q;
    logic signed [T-1:0] y_rdata_q;

    // handshake and pipeline helpers
    logic       tx_fire;
    logic       y_fire;
    logic       fetch_en;
    logic       x_we;
    logic       y_we;
    logic [1:0] occ;
    logic [1:0] occ_after;

    assign tx_fire = out_valid_q && strm.m_ready_x;
    assign y_fire  = strm.s_valid_y && s_ready_y_q;

    // Words held in the output register, the skid entry, or landing from the
    // RAM this cycle. A new read is only issued if, after this cycle's pop,
    // there is still room for it when it lands next cycle; this keeps the
    // total never above the two storage slots.
    assign occ       = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(rvalid_q);
    assign occ_after = occ - 2'(tx_fire);
    assign fetch_en  = (state_q == ST_RUN) && (fetch_idx_q < N_C) && (occ_after < 2'd2);

    assign x_we = (state_q == ST_IDLE) && wr_en;
    assign y_we = y_fire && !reset;

    // X buffer: host writes only while idle, registered read feeds the prefetch
    always_ff @(posedge clk) begin
        if (x_we) begin
            x_mem[wr_addr] <= wr_data;
        end
        if (fetch_en) begin
            x_rdata_q <= x_mem[fetch_idx_q[XA-1:0]];
        end
    end

    // Y buffer: results stored in arrival order, read port returns the old word on collision
    always_ff @(posedge clk) begin
        if (y_we) begin
            y_mem[y_count_q[YA-1:0]] <= strm.s_data_y;
        end
        y_rdata_q <= y_mem[rd_addr];
    end

    // Next-state logic: transfer FSM, TX prefetch queue and RX counter
    always_comb begin
        state_d      = state_q;
        tx_cnt_d     = tx_cnt_q;
        fetch_idx_d  = fetch_idx_q;
        rvalid_d     = fetch_en;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        s_ready_y_d  = s_ready_y_q;
        y_count_d    = y_count_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        // Two-slot in-order queue: the output register is the head, the skid
        // entry is second. The RAM word that lands this cycle goes behind
        // whatever survives this cycle's pop.
        if (out_valid_q && !tx_fire) begin
            if (!skid_valid_q) begin
                skid_valid_d = rvalid_q;
                skid_data_d  = rvalid_q ? x_rdata_q : skid_data_q;
            end
        end else if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = rvalid_q;
            skid_data_d  = rvalid_q ? x_rdata_q : skid_data_q;
        end else if (rvalid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = x_rdata_q;
            skid_valid_d = 1'b0;
        end else begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    tx_cnt_d    = '0;
                    fetch_idx_d = '0;
                    y_count_d   = '0;
                    busy_d      = 1'b1;
                    s_ready_y_d = 1'b1;
                end
            end
            ST_RUN: begin
                tx_cnt_d    = tx_cnt_q + TC_W'(tx_fire);
                fetch_idx_d = fetch_idx_q + TC_W'(fetch_en);
                y_count_d   = y_count_q + YC_W'(y_fire);
                s_ready_y_d = (y_count_d < Y_LEN_C);
                // Leave as soon as both directions have their last beat,
                // whichever finished later.
                if ((tx_cnt_d == N_C) && (y_count_d == Y_LEN_C)) begin
                    state_d     = ST_DONE;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    s_ready_y_d = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                busy_d      = 1'b0;
                s_ready_y_d = 1'b0;
            end
        endcase
    end

    // Register all control state; reset drops any beat in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tx_cnt_q     <= '0;
            fetch_idx_q  <= '0;
            rvalid_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            s_ready_y_q  <= 1'b0;
            y_count_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_cnt_q     <= tx_cnt_d;
            fetch_idx_q  <= fetch_idx_d;
            rvalid_q     <= rvalid_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            s_ready_y_q  <= s_ready_y_d;
            y_count_q    <= y_count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign strm.m_valid_x = out_valid_q;
    assign strm.m_data_x  = out_data_q;
    assign strm.s_ready_y = s_ready_y_q;
    assign rd_data        = y_rdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign y_count        = y_count_q;

endmodule

// File: doc/conv_stream_driver.md
# conv_stream_driver

Stream endpoint that drives and terminates the conv_128_32_8_1 datapath. It holds an N-word X vector loaded by the host and transmits it as a valid/ready master into the convolver's X slave port. It accepts the N-M+1 results from the convolver's Y master port as a valid/ready slave and stores them for host readback. It sits between the host/test harness and the convolver and is the far end of both of the convolver's stream interfaces.

## Interface
- T, 8, data word width (signed)
- N, 128, X vector length
- M, 32, filter length; result count Y_LEN = N-M+1 (97 at defaults)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- wr_en  in  1  host write strobe into X buffer
- wr_addr  in  $clog2(N)  X buffer write index
- wr_data  in  T  signed X word
- start  in  1  begin one transfer (sampled in IDLE only)
- m_valid_x  out  1  X word valid to convolver
- m_data_x  out  T  signed X word to convolver
- m_ready_x  in  1  convolver ready (s_ready_x)
- s_valid_y  in  1  convolver result valid (m_valid_y)
- s_data_y  in  T  signed result word
- s_ready_y  out  1  driver ready for result
- rd_addr  in  $clog2(Y_LEN)  host Y buffer read index
- rd_data  out  T  Y buffer word, 1-cycle synchronous read
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at end of transfer
- y_count  out  $clog2(Y_LEN+1)  results accepted in current/last transfer

## Operation
- States: IDLE, RUN, DONE.
- IDLE: wr_en writes wr_data to X[wr_addr]. start=1 -> RUN; tx_cnt, y_count cleared to 0.
- RUN, TX side: words X[0..N-1] are sent in order. A beat completes on a cycle with m_valid_x && m_ready_x. m_data_x is held stable and m_valid_x stays high until acceptance. After beat N completes, m_valid_x=0 for the rest of the transfer.
- Prefetch: the X buffer has synchronous-read latency of 1 cycle. A one-entry output register plus one skid entry must sustain one beat per cycle with m_ready_x held high. There must be no bubbles after the first beat, and no duplicated or skipped indices under any m_ready_x pattern.
- RUN, RX side: s_ready_y=1 while y_count<Y_LEN. On s_valid_y && s_ready_y, s_data_y is written to Y[y_count] and y_count increments. Once y_count==Y_LEN, s_ready_y=0 and further results are not accepted.
- TX and RX run concurrently and independently. Results arriving before TX finishes are accepted.
- RUN -> DONE when tx_cnt==N and y_count==Y_LEN. DONE lasts one cycle with done=1, then goes to IDLE. y_count holds its final value until the next start.
- During RUN/DONE, wr_en and start are ignored.
- rd_addr/rd_data are valid in any state. Reading during RUN returns whatever the buffer currently holds.
- Data passes through unmodified (signed T bits). No arithmetic other than counters.

## Timing
- Reset values: m_valid_x=0, m_data_x=0, s_ready_y=0, busy=0, done=0, y_count=0, state=IDLE. X/Y buffer contents are not reset.
- Reset mid-RUN takes effect at the next edge: all outputs return to reset values and any in-flight beat is dropped. A following start restarts from X[0].
- start sampled high at edge e: busy=1 and s_ready_y=1 after e; m_valid_x first high after edge e+2, carrying X[0].
- With m_ready_x constantly high, the last beat (X[N-1]) completes in the cycle after edge e+N+1.
- done is asserted in the cycle after the edge that completes the last outstanding beat (TX or RX, whichever is later). busy drops in the same cycle done rises.
- Simultaneous final TX beat and final RX beat in one cycle: both are counted, then DONE follows next.
- Write to X[a] in the same cycle as start: the write takes effect and is visible to the transfer.
- rd_data reflects Y[rd_addr] one cycle after rd_addr is presented. A same-cycle Y write and read of the same address returns the old value.

## Test plan
- Load X[i]=i-64, start, m_ready_x=1 constant -> 128 consecutive beats −64..63 starting 2 cycles after start; m_valid_x=0 afterwards.
- Same load, m_ready_x driven by an LFSR pattern (~50% duty) -> exactly 128 beats, in order; m_data_x stable on every stalled cycle.
- s_valid_y high with data k+1 for beats k=0..96, then a 98th valid -> Y[0..96]=1..97; 98th not accepted (s_ready_y=0); y_count=97; done pulses exactly once.
- Reset asserted after 50 TX beats -> next cycle m_valid_x=0, busy=0, y_count=0; a new start resends X[0] first.
- During RUN, pulse start and write X[0]=127 -> no restart; the transmitted sequence and a later readback of X through a second transfer show X[0] changed only when written in IDLE.
- End-to-end: connect to conv_128_32_8_1 with random X, random m_ready_x stalls -> 97 stored Y values match the golden saturating/ReLU model.
